// File: rtl/btb_train_queue.sv
// BTB training queue: buffers branch resolutions that mispredicted, drains one BTB write per
// cycle and raises a registered redirect. Optional macro BTB_WR_COALESCE_EN merges same-PC pairs.
module btb_train_queue #(
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        alu_0_valid,
   input  logic [63:0] alu_0_pc,
   input  logic [63:0] alu_0_pred_npc,
   input  logic        alu_0_taken,
   input  logic [63:0] alu_0_target,
   input  logic        alu_1_valid,
   input  logic [63:0] alu_1_pc,
   input  logic [63:0] alu_1_pred_npc,
   input  logic        alu_1_taken,
   input  logic [63:0] alu_1_target,
   output logic        btb_wr_en,
   output logic [63:0] btb_wr_pc,
   output logic [63:0] btb_wr_npc,
   output logic        mispredict,
   output logic [63:0] mispredict_npc,
   output logic        queue_full
);

   localparam int unsigned AW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [63:0]   pc_mem_q  [QUEUE_DEPTH];
   logic [63:0]   pc_mem_d  [QUEUE_DEPTH];
   logic [63:0]   npc_mem_q [QUEUE_DEPTH];
   logic [63:0]   npc_mem_d [QUEUE_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx_1;
   logic [CW-1:0] count_q, count_d, free, need_1;
   logic          btb_wr_en_q, btb_wr_en_d, mispredict_q, mispredict_d;
   logic          queue_full_q, queue_full_d;
   logic [63:0]   btb_wr_pc_q, btb_wr_pc_d, btb_wr_npc_q, btb_wr_npc_d;
   logic [63:0]   mispredict_npc_q, mispredict_npc_d;
   logic [63:0]   correct_npc_0, correct_npc_1;
   logic          mis_0, mis_1, enq_0_req, enq_1_req, enq_0, enq_1, deq;
   logic          unused_pred_lsb;

   // Prediction check ignores the instruction-alignment bits.
   assign unused_pred_lsb = ^{alu_0_pred_npc[1:0], alu_1_pred_npc[1:0]};

   always_comb begin
      correct_npc_0 = alu_0_taken ? alu_0_target : alu_0_pc + 64'd4;
      correct_npc_1 = alu_1_taken ? alu_1_target : alu_1_pc + 64'd4;
      mis_0 = alu_0_valid && (correct_npc_0[63:2] != alu_0_pred_npc[63:2]);
      mis_1 = alu_1_valid && (correct_npc_1[63:2] != alu_1_pred_npc[63:2]);

      enq_0_req = mis_0;
      enq_1_req = mis_1;
`ifdef BTB_WR_COALESCE_EN
      if (mis_0 && mis_1 && (alu_0_pc[63:2] == alu_1_pc[63:2])) enq_0_req = 1'b0;
`endif

      // Space is judged before this cycle's pop; ALU 1 loses first.
      free   = CW'(QUEUE_DEPTH) - count_q;
      enq_0  = enq_0_req && (free >= CW'(1));
      need_1 = enq_0 ? CW'(2) : CW'(1);
      enq_1  = enq_1_req && (free >= need_1);
      deq    = (count_q != '0);

      wr_idx_1  = enq_0 ? wr_ptr_q + AW'(1) : wr_ptr_q;
      pc_mem_d  = pc_mem_q;
      npc_mem_d = npc_mem_q;
      if (enq_0) begin
         pc_mem_d[wr_ptr_q]  = {alu_0_pc[63:2], 2'b00};
         npc_mem_d[wr_ptr_q] = {correct_npc_0[63:2], 2'b00};
      end
      if (enq_1) begin
         pc_mem_d[wr_idx_1]  = {alu_1_pc[63:2], 2'b00};
         npc_mem_d[wr_idx_1] = {correct_npc_1[63:2], 2'b00};
      end

      wr_ptr_d = wr_ptr_q + AW'(enq_0) + AW'(enq_1);
      rd_ptr_d = rd_ptr_q + AW'(deq);
      count_d  = count_q + CW'(enq_0) + CW'(enq_1) - CW'(deq);
      queue_full_d = (count_d >= CW'(QUEUE_DEPTH - 1));

      btb_wr_en_d  = deq;
      btb_wr_pc_d  = deq ? pc_mem_q[rd_ptr_q]  : btb_wr_pc_q;
      btb_wr_npc_d = deq ? npc_mem_q[rd_ptr_q] : btb_wr_npc_q;

      mispredict_d     = mis_0 || mis_1;
      mispredict_npc_d = mis_0 ? correct_npc_0 : (mis_1 ? correct_npc_1 : mispredict_npc_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         queue_full_q     <= 1'b0;
         btb_wr_en_q      <= 1'b0;
         btb_wr_pc_q      <= '0;
         btb_wr_npc_q     <= '0;
         mispredict_q     <= 1'b0;
         mispredict_npc_q <= '0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         queue_full_q     <= queue_full_d;
         btb_wr_en_q      <= btb_wr_en_d;
         btb_wr_pc_q      <= btb_wr_pc_d;
         btb_wr_npc_q     <= btb_wr_npc_d;
         mispredict_q     <= mispredict_d;
         mispredict_npc_q <= mispredict_npc_d;
      end
   end

   // Entry storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clock) begin
      pc_mem_q  <= pc_mem_d;
      npc_mem_q <= npc_mem_d;
   end

   assign btb_wr_en      = btb_wr_en_q;
   assign btb_wr_pc      = btb_wr_pc_q;
   assign btb_wr_npc     = btb_wr_npc_q;
   assign mispredict     = mispredict_q;
   assign mispredict_npc = mispredict_npc_q;
   assign queue_full     = queue_full_q;

endmodule

// File: tb/tb_btb_train_queue.sv
// Bench for btb_train_queue: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_btb_train_queue;

   localparam int unsigned DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        v0, tk0, v1, tk1;
   logic [63:0] pc0, pr0, tg0, pc1, pr1, tg1;
   logic        btb_wr_en, mispredict, queue_full;
   logic [63:0] btb_wr_pc, btb_wr_npc, mispredict_npc;

   btb_train_queue #(.QUEUE_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .alu_0_valid(v0), .alu_0_pc(pc0), .alu_0_pred_npc(pr0), .alu_0_taken(tk0),
      .alu_0_target(tg0),
      .alu_1_valid(v1), .alu_1_pc(pc1), .alu_1_pred_npc(pr1), .alu_1_taken(tk1),
      .alu_1_target(tg1),
      .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_npc(btb_wr_npc),
      .mispredict(mispredict), .mispredict_npc(mispredict_npc), .queue_full(queue_full)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] npc;
   } ent_t;

   ent_t        mq[$];
   logic        e_wr_en, e_mis, e_full;
   logic [63:0] e_wr_pc, e_wr_npc, e_mis_npc;
   bit          model_ready = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: applies the resolution rules to the inputs sampled at the last edge.
   task automatic model_step();
      logic [63:0] c0, c1;
      logic m0, m1, e0, e1;
      int free;
      if (reset) begin
         mq.delete();
         e_wr_en = 0; e_wr_pc = 0; e_wr_npc = 0; e_mis = 0; e_mis_npc = 0; e_full = 0;
         return;
      end
      c0 = tk0 ? tg0 : pc0 + 64'd4;
      c1 = tk1 ? tg1 : pc1 + 64'd4;
      m0 = v0 && (c0 >> 2) != (pr0 >> 2);
      m1 = v1 && (c1 >> 2) != (pr1 >> 2);
      e_mis = m0 || m1;
      if (m0) e_mis_npc = c0;
      else if (m1) e_mis_npc = c1;
      free = DEPTH - mq.size();
      if (mq.size() > 0) begin
         e_wr_en  = 1;
         e_wr_pc  = mq[0].pc;
         e_wr_npc = mq[0].npc;
         mq.pop_front();
      end else begin
         e_wr_en = 0;
      end
      e0 = m0;
      e1 = m1;
`ifdef BTB_WR_COALESCE_EN
      if (m0 && m1 && (pc0 >> 2) == (pc1 >> 2)) e0 = 0;
`endif
      if (e0 && free >= 1) begin
         mq.push_back('{pc: pc0 & ~64'd3, npc: c0 & ~64'd3});
         free--;
      end
      if (e1 && free >= 1) mq.push_back('{pc: pc1 & ~64'd3, npc: c1 & ~64'd3});
      e_full = (mq.size() >= DEPTH - 1);
   endtask

   always @(negedge clock) begin
      if (model_ready) begin
         chk("wr_en", btb_wr_en, e_wr_en);
         chk("wr_pc", btb_wr_pc, e_wr_pc);
         chk("wr_npc", btb_wr_npc, e_wr_npc);
         chk("mispredict", mispredict, e_mis);
         chk("mispredict_npc", mispredict_npc, e_mis_npc);
         chk("queue_full", queue_full, e_full);
      end
   end

   task automatic cycle();
      @(posedge clock);
      #1;
      model_step();
      model_ready = 1;
   endtask

   task automatic idle();
      v0 = 0; v1 = 0; tk0 = 0; tk1 = 0;
      pc0 = 0; pr0 = 0; tg0 = 0; pc1 = 0; pr1 = 0; tg1 = 0;
   endtask

   // Taken branch at pc predicted fall-through, resolving to target.
   task automatic mis_pair(input logic a0, input logic [63:0] p0, input logic [63:0] t0,
                           input logic a1, input logic [63:0] p1, input logic [63:0] t1);
      v0 = a0; pc0 = p0; pr0 = p0 + 4; tk0 = 1; tg0 = t0;
      v1 = a1; pc1 = p1; pr1 = p1 + 4; tk1 = 1; tg1 = t1;
   endtask

   task automatic drain(input int n);
      idle();
      repeat (n) cycle();
   endtask

   initial begin
      int nwr;
      bit stale;
      idle();
      reset = 1;
      cycle();
      cycle();
      chk("rst_wr_en", btb_wr_en, 0);
      chk("rst_mis", mispredict, 0);
      chk("rst_full", queue_full, 0);
      chk("rst_wr_pc", btb_wr_pc, 0);
      reset = 0;

      // Single ALU 0 mispredict.
      mis_pair(1, 64'h100, 64'h200, 0, 0, 0);
      cycle();
      chk("d31_mis", mispredict, 1);
      chk("d31_npc", mispredict_npc, 64'h200);
      chk("d31_noearly", btb_wr_en, 0);
      idle();
      cycle();
      chk("d31_wr_en", btb_wr_en, 1);
      chk("d31_wr_pc", btb_wr_pc, 64'h100);
      chk("d31_wr_npc", btb_wr_npc, 64'h200);
      drain(3);

      // Both mispredict; ALU 1 not-taken.
      v0 = 1; pc0 = 64'h100; pr0 = 64'h104; tk0 = 1; tg0 = 64'h200;
      v1 = 1; pc1 = 64'h300; pr1 = 64'h400; tk1 = 0; tg1 = 64'h999;
      cycle();
      chk("d32_npc", mispredict_npc, 64'h200);
      idle();
      cycle();
      chk("d32_w1_pc", btb_wr_pc, 64'h100);
      chk("d32_w1_npc", btb_wr_npc, 64'h200);
      cycle();
      chk("d32_w2_en", btb_wr_en, 1);
      chk("d32_w2_pc", btb_wr_pc, 64'h300);
      chk("d32_w2_npc", btb_wr_npc, 64'h304);
      drain(3);

      // Correct prediction leaves no trace.
      v0 = 1; pc0 = 64'h100; pr0 = 64'h104; tk0 = 0; tg0 = 64'h500;
      cycle();
      chk("d34_mis", mispredict, 0);
      idle();
      cycle();
      chk("d34_wr_en", btb_wr_en, 0);

      // Overflow: reach 3 held, then a dual enqueue drops ALU 1.
      mis_pair(1, 64'h1000, 64'h1040, 1, 64'h1100, 64'h1140);
      cycle();
      mis_pair(1, 64'h1200, 64'h1240, 1, 64'h1300, 64'h1340);
      cycle();
      chk("d33_full_pre", queue_full, 1);
      mis_pair(1, 64'h1400, 64'h1440, 1, 64'h1500, 64'h1540);
      cycle();
      chk("d33_full", queue_full, 1);
      nwr = btb_wr_en;
      idle();
      cycle();
      chk("d33_full_off", queue_full, 0);
      stale = 0;
      for (int i = 0; i < 7; i++) begin
         nwr += btb_wr_en;
         if (btb_wr_en && btb_wr_pc == 64'h1500) stale = 1;
         cycle();
      end
      chk("d33_writes", nwr, 4);
      chk("d33_dropped", stale, 0);

      // Reset with 3 entries queued.
      mis_pair(1, 64'h2000, 64'h2040, 1, 64'h2100, 64'h2140);
      cycle();
      mis_pair(1, 64'h2200, 64'h2240, 1, 64'h2300, 64'h2340);
      cycle();
      reset = 1;
      mis_pair(1, 64'h2400, 64'h2440, 1, 64'h2500, 64'h2540);
      cycle();
      chk("d35_wr_en", btb_wr_en, 0);
      chk("d35_mis", mispredict, 0);
      reset = 0;
      idle();
      nwr = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         nwr += btb_wr_en;
      end
      chk("d35_nowrites", nwr, 0);

      // Same-PC pair.
      mis_pair(1, 64'h100, 64'h200, 1, 64'h100, 64'h300);
      cycle();
      idle();
      cycle();
`ifdef BTB_WR_COALESCE_EN
      chk("d36_npc", btb_wr_npc, 64'h300);
      cycle();
      chk("d36_single", btb_wr_en, 0);
`else
      chk("d36_npc1", btb_wr_npc, 64'h200);
      cycle();
      chk("d36_pc2", btb_wr_pc, 64'h100);
      chk("d36_npc2", btb_wr_npc, 64'h300);
`endif
      drain(3);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [63:0] base [4];
         logic [63:0] c;
         base[0] = 64'h100; base[1] = 64'h200; base[2] = 64'hFFFF_FFFF_FFFF_FFFC;
         base[3] = {$urandom, $urandom};
         reset = ($urandom_range(0, 199) == 0);
         v0  = ($urandom_range(0, 2) != 0);
         v1  = ($urandom_range(0, 2) != 0);
         pc0 = base[$urandom_range(0, 3)] | 64'($urandom_range(0, 3));
         pc1 = ($urandom_range(0, 3) == 0) ? pc0 : base[$urandom_range(0, 3)];
         tk0 = $urandom_range(0, 1);
         tk1 = $urandom_range(0, 1);
         tg0 = {$urandom, $urandom};
         tg1 = ($urandom_range(0, 3) == 0) ? 64'h40 : {$urandom, $urandom};
         c   = tk0 ? tg0 : pc0 + 4;
         pr0 = ($urandom_range(0, 1) != 0) ? (c ^ 64'($urandom_range(0, 3))) : {$urandom, $urandom};
         c   = tk1 ? tg1 : pc1 + 4;
         pr1 = ($urandom_range(0, 1) != 0) ? (c ^ 64'($urandom_range(0, 3))) : {$urandom, $urandom};
         cycle();
      end
      reset = 0;
      drain(8);
      model_ready = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btb_train_queue.md
BTB_TRAIN_QUEUE -- requirements
Module: btb_train_queue

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, number of buffered BTB write entries; power of two, minimum 2.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_0_valid  input  1  ALU 0 resolves a branch this cycle; ALU 0 is the older slot.
REQ-005 alu_0_pc  input  64  PC of the ALU 0 branch.
REQ-006 alu_0_pred_npc  input  64  next PC predicted at fetch for the ALU 0 branch.
REQ-007 alu_0_taken  input  1  actual direction of the ALU 0 branch.
REQ-008 alu_0_target  input  64  actual taken target of the ALU 0 branch.
REQ-009 alu_1_valid, alu_1_pc, alu_1_pred_npc, alu_1_taken, alu_1_target  input  1/64/64/1/64  same as REQ-004..008 for ALU 1, the younger slot.
REQ-010 btb_wr_en  output  1  BTB write strobe, one entry per cycle.
REQ-011 btb_wr_pc  output  64  PC of the entry being written, bits [1:0] forced to 0.
REQ-012 btb_wr_npc  output  64  corrected next PC for that entry, bits [1:0] forced to 0.
REQ-013 mispredict  output  1  registered flush request to fetch.
REQ-014 mispredict_npc  output  64  redirect PC accompanying mispredict.
REQ-015 queue_full  output  1  registered; fewer than 2 free slots; upstream stalls branch issue.

Function
REQ-016 correct_npc_k = alu_k_taken ? alu_k_target : alu_k_pc + 4, 64-bit wrap-around arithmetic.
REQ-017 mis_k = alu_k_valid && (correct_npc_k != alu_k_pred_npc), comparison on bits [63:2] only.
REQ-018 mispredict and mispredict_npc are registered one cycle after the resolving cycle. If mis_0, report correct_npc_0 and ignore ALU 1 for redirect. Otherwise, if mis_1, report correct_npc_1. Otherwise mispredict=0 and mispredict_npc holds its previous value.
REQ-019 Enqueue request enq_k = mis_k. Training is a hint, so the younger slot is NOT squashed for training when mis_0 is set.
REQ-020 Entries are stored in circular order with wrapping read/write pointers and a count of width log2(QUEUE_DEPTH)+1. An entry holds {pc, correct_npc}. When both ALUs enqueue in the same cycle, ALU 0 is written before ALU 1.
REQ-021 Free space for a cycle is computed from count before that cycle's dequeue. Requests with no slot are dropped, ALU 1 first, and leave no state change.
REQ-022 Dequeue: when count>0, the head is popped and presented registered next cycle on btb_wr_en=1 with btb_wr_pc/btb_wr_npc. When count==0, btb_wr_en=0 and data holds.
REQ-023 Latency from resolution to btb_wr_en is at least 2 cycles when the queue is empty; simultaneous enqueue and dequeue are permitted.
REQ-024 queue_full is registered from next-state count >= QUEUE_DEPTH-1.
REQ-025 Pointer wrap at QUEUE_DEPTH-1 -> 0 is seamless; count never exceeds QUEUE_DEPTH and never underflows.

Reset
REQ-026 On reset: pointers=0, count=0, btb_wr_en=0, btb_wr_pc=0, btb_wr_npc=0, mispredict=0, mispredict_npc=0, queue_full=0.
REQ-027 Reset mid-operation flushes all queued entries. No BTB write or mispredict is emitted in the cycle after reset.
REQ-028 Reset has priority over all simultaneous inputs.

Configuration
REQ-029 Macro BTB_WR_COALESCE_EN, when defined: if enq_0 and enq_1 in the same cycle have equal pc[63:2], only the ALU 1 entry is enqueued (one slot used).
REQ-030 Without BTB_WR_COALESCE_EN: both entries are enqueued per REQ-020; the BTB sees two writes to the same PC, last wins.

Verification
REQ-031 ALU0 valid, pc=0x100, pred_npc=0x104, taken=1, target=0x200 -> next cycle mispredict=1, npc=0x200; 2 cycles later btb_wr_en=1, pc=0x100, npc=0x200.
REQ-032 Both ALUs mispredict in one cycle (pc 0x100->0x200, pc 0x300->0x304 not-taken, pred 0x400) -> mispredict_npc=0x200; two consecutive BTB writes in order 0x100 then 0x300.
REQ-033 QUEUE_DEPTH=4, 3 entries held, dual enqueue -> ALU1 entry dropped, queue_full=1, exactly 4 writes drain, queue_full deasserts when count<=2.
REQ-034 Correct prediction, pred_npc=0x104, not-taken, pc=0x100 -> no mispredict, no BTB write.
REQ-035 Reset asserted with 3 entries queued -> btb_wr_en=0 for all subsequent idle cycles; no stale entry emitted.
REQ-036 With BTB_WR_COALESCE_EN, both ALUs mispredict at pc=0x100 with targets 0x200/0x300 -> single write 0x100->0x300; without the macro -> two writes, 0x200 then 0x300.
